// File: rtl/ysyx_22041412_csr_pkg.sv
// Shared constants for the EX-stage CSR issue logic: CSR addresses, unit indices,
// func3 codes and the issue FSM encoding.
package ysyx_22041412_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] IDX_MRET    = 3'd0;
  localparam logic [2:0] IDX_ECALL   = 3'd1;
  localparam logic [2:0] IDX_MSTATUS = 3'd2;
  localparam logic [2:0] IDX_MTVEC   = 3'd3;
  localparam logic [2:0] IDX_MEPC    = 3'd4;
  localparam logic [2:0] IDX_MCAUSE  = 3'd5;

  localparam logic [2:0] F3_SYS = 3'b000;
  localparam logic [2:0] F3_RSV = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_22041412_csr_addr_map.sv
// Maps a 12-bit machine-mode CSR address onto the CSR unit's 3-bit index.
module ysyx_22041412_csr_addr_map
  import ysyx_22041412_csr_pkg::*;
(
  input  logic [11:0] csr,
  output logic [2:0]  idx,
  output logic        hit
);

  always_comb begin
    idx = IDX_MRET;
    hit = 1'b0;
    case (csr)
      CSR_MSTATUS: begin idx = IDX_MSTATUS; hit = 1'b1; end
      CSR_MTVEC:   begin idx = IDX_MTVEC;   hit = 1'b1; end
      CSR_MEPC:    begin idx = IDX_MEPC;    hit = 1'b1; end
      CSR_MCAUSE:  begin idx = IDX_MCAUSE;  hit = 1'b1; end
      default:     begin idx = IDX_MRET;    hit = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_csr_issue.sv
// Issues one CSR/ECALL/MRET op to the machine-mode CSR unit and returns rd or a redirect.
//   state  | meaning
//   S_IDLE | waiting for an op; the only state that accepts
//   S_REQ  | csr_en high, waiting for csr_ready or timeout
//   S_DONE | one-cycle response; csr_en low so the unit's ready clears
module ysyx_22041412_csr_issue
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_func3,
  input  logic [11:0] req_csr,
  input  logic        req_is_ecall,
  input  logic        req_is_mret,
  input  logic [63:0] req_rs1,
  input  logic [4:0]  req_zimm,
  input  logic [63:0] req_pc,
  input  logic        flush,
  output logic        csr_en,
  output logic [2:0]  csr_addr,
  output logic [2:0]  csr_func3,
  output logic [63:0] csr_wdata,
  output logic [63:0] csr_pc,
  input  logic [63:0] csr_rdata,
  input  logic        csr_ready,
  output logic        busy,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        illegal,
  output logic        timeout_err
);

  state_t           state, state_nxt;
  logic [2:0]       map_idx;
  logic             map_hit;
  logic             is_system, sys_ok, csr_ok, req_ok, accept;
  logic             is_sys_q, illegal_q, kill_q;
  logic [63:0]      result_q;
  logic [CNT_W-1:0] cnt;

  ysyx_22041412_csr_addr_map u_addr_map (
    .csr (req_csr),
    .idx (map_idx),
    .hit (map_hit)
  );

  assign is_system = (req_func3 == F3_SYS);
  assign sys_ok    = is_system & (req_is_ecall ^ req_is_mret);
  assign csr_ok    = !is_system & (req_func3 != F3_RSV) & map_hit;
  assign req_ok    = sys_ok | csr_ok;
  assign accept    = (state == S_IDLE) & req_valid & !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    csr_en         = 1'b0;
    busy           = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 64'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    illegal        = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = req_ok ? S_REQ : S_DONE;
      S_REQ: begin
        csr_en = 1'b1;
        busy   = 1'b1;
        if (csr_ready || cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        // A killed op still ran in the CSR unit; only its architectural result is hidden.
        resp_valid = !kill_q & !flush;
        if (resp_valid) begin
          illegal        = illegal_q;
          resp_rdata     = is_sys_q ? 64'd0 : result_q;
          redirect_valid = is_sys_q & !illegal_q;
          redirect_pc    = redirect_valid ? result_q : 64'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_addr    <= 3'd0;
      csr_func3   <= 3'd0;
      csr_wdata   <= 64'd0;
      csr_pc      <= 64'd0;
      is_sys_q    <= 1'b0;
      illegal_q   <= 1'b0;
      kill_q      <= 1'b0;
      result_q    <= 64'd0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        csr_func3 <= is_system ? F3_SYS : req_func3;
        csr_addr  <= is_system ? (req_is_ecall ? IDX_ECALL : IDX_MRET) : map_idx;
        csr_wdata <= is_system ? 64'd0 :
                     (req_func3[2] ? {59'd0, req_zimm} : req_rs1);
        csr_pc    <= req_pc;
        is_sys_q  <= is_system;
        illegal_q <= !req_ok;
        kill_q    <= 1'b0;
        result_q  <= 64'd0;
        cnt       <= CNT_W'(TIMEOUT_CYCLES - 1);
      end
      if (state == S_REQ) begin
        if (flush) kill_q <= 1'b1;
        if (csr_ready) begin
          result_q <= csr_rdata;
        end else if (cnt == '0) begin
          illegal_q   <= 1'b1;
          timeout_err <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
